// File: rtl/disp_pkg.sv
// Shared display-scan definitions: scan FSM states, default geometry and
// scan-source select codes.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam int DEFAULT_NUM_DIGITS  = 4;
  localparam int DEFAULT_DEAD_CYCLES = 64;

  localparam int SCAN_1525 = 0;
  localparam int SCAN_762  = 1;

endpackage

// File: rtl/edge_tick_sync.sv
// Brings one asynchronous divided clock into clk_50MHz and emits a one-cycle
// registered tick for each rising edge seen after synchronisation.
module edge_tick_sync (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [2:0] vld;

  // vld marks when s3 holds a genuinely sampled value, so an input that was
  // already high through reset does not look like a fresh rising edge.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      vld  <= '0;
      tick <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s3   <= s2;
      vld  <= {vld[1:0], 1'b1};
      tick <= s2 & ~s3 & vld[2];
    end
  end

endmodule

// File: rtl/scan_tick_controller.sv
// Converts the divided clocks into clk_50MHz tick enables and sequences the
// multiplexed 7-segment anodes with a dead-time blanking gap between digits.
module scan_tick_controller
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int DEAD_CYCLES = DEFAULT_DEAD_CYCLES,
  parameter int SCAN_SEL    = SCAN_1525,
  localparam int IDXW       = $clog2(NUM_DIGITS)
) (
  input  logic                  clk_50MHz,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr_overrun,
  input  logic                  clk_24Hz,
  input  logic                  clk_762Hz,
  input  logic                  clk_1525Hz,
  input  logic                  clk_1Hz,
  output logic                  tick_24Hz,
  output logic                  tick_762Hz,
  output logic                  tick_1525Hz,
  output logic                  tick_1Hz,
  output logic [NUM_DIGITS-1:0] digit_an,
  output logic [IDXW-1:0]       digit_idx,
  output logic                  scan_active,
  output logic                  overrun
);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_bad_dead_cycles
    $error("scan_tick_controller: DEAD_CYCLES must be in 1..255");
  end
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("scan_tick_controller: NUM_DIGITS must be in 2..8");
  end
  if (SCAN_SEL != SCAN_1525 && SCAN_SEL != SCAN_762) begin : g_bad_scan_sel
    $error("scan_tick_controller: SCAN_SEL must be 0 or 1");
  end

  localparam logic [7:0]      DEAD_LOAD = 8'(DEAD_CYCLES);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_DIGITS - 1);

  edge_tick_sync u_sync_24hz (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .async_in  (clk_24Hz),
    .tick      (tick_24Hz)
  );

  edge_tick_sync u_sync_762hz (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .async_in  (clk_762Hz),
    .tick      (tick_762Hz)
  );

  edge_tick_sync u_sync_1525hz (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .async_in  (clk_1525Hz),
    .tick      (tick_1525Hz)
  );

  edge_tick_sync u_sync_1hz (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .async_in  (clk_1Hz),
    .tick      (tick_1Hz)
  );

  logic scan_tick;
  assign scan_tick = (SCAN_SEL == SCAN_762) ? tick_762Hz : tick_1525Hz;

  scan_state_t           state_q;
  scan_state_t           state_d;
  logic [IDXW-1:0]       idx_d;
  logic [7:0]            dead_q;
  logic [7:0]            dead_d;
  logic                  ov_d;
  logic [NUM_DIGITS-1:0] an_d;

  always_comb begin
    state_d = state_q;
    idx_d   = digit_idx;
    dead_d  = dead_q;
    ov_d    = overrun;

    if (clr_overrun) begin
      ov_d = 1'b0;
    end
    if (state_q == BLANK && scan_tick) begin
      ov_d = 1'b1;
    end

    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          dead_d  = DEAD_LOAD;
        end
        BLANK: begin
          if (dead_q == 8'd1) begin
            state_d = DRIVE;
          end else begin
            dead_d = dead_q - 8'd1;
          end
        end
        DRIVE: begin
          if (scan_tick) begin
            state_d = BLANK;
            dead_d  = DEAD_LOAD;
            idx_d   = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Anodes are decoded from the next state so they stay registered yet
    // switch on the same edge as the state and index.
    an_d = '1;
    if (state_d == DRIVE) begin
      an_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dead_q      <= '0;
      digit_idx   <= '0;
      digit_an    <= '1;
      scan_active <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dead_q      <= dead_d;
      digit_idx   <= idx_d;
      digit_an    <= an_d;
      scan_active <= (state_d == DRIVE);
      overrun     <= ov_d;
    end
  end

endmodule
